// File: rtl/atari_bank_mapper_if.sv
// Cartridge bus bundle for atari_bank_mapper: CPU cart-window access, SPI loader
// write port and the read-data / bank-status returns.
interface atari_bank_mapper_if #(
  parameter int unsigned BANKS      = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AW         = $clog2(BANKS * 4096)
);
  logic [12:0]           cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_din;
  logic                  cpu_rnw;
  logic                  acc_stb;
  logic                  load_we;
  logic [AW-1:0]         load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] dout;
  logic [2:0]            bank;
  logic                  switch_pulse;

  // Driven by the CPU/loader side.
  modport master (
    output cpu_addr, cpu_din, cpu_rnw, acc_stb, load_we, load_addr, load_data,
    input  dout, bank, switch_pulse
  );

  // Seen by the mapper.
  modport slave (
    input  cpu_addr, cpu_din, cpu_rnw, acc_stb, load_we, load_addr, load_data,
    output dout, bank, switch_pulse
  );
endinterface

// File: rtl/atari_bank_mapper.sv
// Atari 2600 bank-switching cartridge mapper (plain 4K / F8 / F6 / F4).
// Holds BANKS x 4 KB of image in RAM, decodes hotspots to pick the visible bank,
// and accepts image writes from the loader at any time.
// Optional feature: define ATARI_SUPERCHIP_EN to add the 128-byte superchip RAM
// at cart offsets $000-$0FF (write port low half, read port high half).
module atari_bank_mapper #(
  parameter int unsigned BANKS      = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AW         = $clog2(BANKS * 4096)
) (
  input logic               clk,
  input logic               reset_n,
  atari_bank_mapper_if.slave bus
);

  localparam int unsigned Depth     = BANKS * 4096;
  localparam logic [11:0] HotBase   = (BANKS == 8) ? 12'hFF4 :
                                      (BANKS == 4) ? 12'hFF6 : 12'hFF8;
  localparam logic [11:0] HotTop    = HotBase + 12'(BANKS) - 12'd1;
  localparam logic [2:0]  BankReset = 3'(BANKS - 1);
  localparam logic        HasHot    = (BANKS > 1);

  logic [11:0]           w_offset;
  logic                  w_in_cart;
  logic                  w_hot;
  logic [11:0]           w_diff;
  logic [2:0]            w_sel;
  logic [AW-1:0]         w_rom_addr;
  logic [AW-1:0]         w_load_addr;
  logic [DATA_WIDTH-1:0] w_rom_rd;
  logic [DATA_WIDTH-1:0] w_rd_data;

  logic [DATA_WIDTH-1:0] r_rom [Depth];
  logic [DATA_WIDTH-1:0] r_dout;
  logic [2:0]            r_bank;
  logic                  r_switch;

  assign w_offset    = bus.cpu_addr[11:0];
  assign w_in_cart   = bus.cpu_addr[12];
  assign w_load_addr = bus.load_addr;

  // Range check gates the subtraction so out-of-range offsets never reach r_bank.
  assign w_hot  = HasHot && bus.acc_stb && w_in_cart &&
                  (w_offset >= HotBase) && (w_offset <= HotTop);
  assign w_diff = w_offset - HotBase;
  assign w_sel  = w_diff[2:0];

  assign w_rom_addr = AW'({r_bank, w_offset});
  assign w_rom_rd   = r_rom[w_rom_addr];

  // Image write port; no reset so the loaded cartridge survives reset_n.
  always_ff @(posedge clk) begin
    if (bus.load_we) begin
      r_rom[w_load_addr] <= bus.load_data;
    end
  end

`ifdef ATARI_SUPERCHIP_EN
  logic [DATA_WIDTH-1:0] r_ram [128];
  logic                  w_ram_we;
  logic                  w_ram_win;

  assign w_ram_win = (w_offset[11:8] == 4'h0);
  assign w_ram_we  = bus.acc_stb && w_in_cart && !bus.cpu_rnw && (w_offset[11:7] == 5'd0);

  // Superchip RAM write port (offsets $000-$07F).
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_offset[6:0]] <= bus.cpu_din;
    end
  end

  // Read source select: RAM read port at $080-$0FF, write port reads as all ones.
  always_comb begin
    w_rd_data = w_rom_rd;
    if (w_ram_win) begin
      w_rd_data = w_offset[7] ? r_ram[w_offset[6:0]] : '1;
    end
  end
`else
  logic w_unused;
  assign w_unused  = ^{bus.cpu_din, bus.cpu_rnw};
  assign w_rd_data = w_rom_rd;
`endif

  // Registered read data, sampled every clk regardless of acc_stb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout <= '0;
    end else begin
      r_dout <= w_rd_data;
    end
  end

  // Bank select: loader writes take priority and park the bank at the top.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank   <= BankReset;
      r_switch <= 1'b0;
    end else if (bus.load_we) begin
      r_bank   <= BankReset;
      r_switch <= 1'b0;
    end else if (w_hot) begin
      r_bank   <= w_sel;
      r_switch <= 1'b1;
    end else begin
      r_switch <= 1'b0;
    end
  end

  assign bus.dout         = r_dout;
  assign bus.bank         = r_bank;
  assign bus.switch_pulse = r_switch;

endmodule
